mmio_arbiter: RTL and testbench

Two-master round-robin arbiter for the single-cycle-style memory-mapped peripheral bus (valid/ready, 32-bit address/data, 4-bit write strobe). It sits between the CPU data port (master 0) and a secondary master such as a debug or DMA engine (master 1), and the shared peripheral fabric (GPIO, UART, timer). It serialises accesses, latches each request for the duration of the slave access, and returns the read data and a one-cycle ready to the owning master only.

---
 rtl/mmio_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mmio_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master round-robin arbiter for the valid/ready MMIO bus.
// Master 0 is the CPU data port, master 1 a secondary (debug/DMA) master.
// Each access runs IDLE -> BUSY -> DONE; request fields are latched at grant.
// Optional build macro MMIO_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a
// stalled access after TIMEOUT_CYCLES cycles and returns 32'hFFFF_FFFF.
module mmio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    // Legal watchdog range is 1..255 (8-bit counter).
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mmio_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = master 0, 1 = master 1
    logic        last_q, last_d;     // most recent winner, loses the next tie
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        timeout_q, timeout_d;
    logic        win;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q, cnt_d;

    // Watchdog counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
`endif

    // State and datapath registers; reset kills any in-flight access at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            s_addr_q   <= 32'd0;
            s_wdata_q  <= 32'd0;
            s_wstrb_q  <= 4'd0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            timeout_q  <= timeout_d;
        end
    end

    // Arbitration, request latching, completion capture and abort.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        timeout_d  = 1'b0;
        win        = 1'b0;
`ifdef MMIO_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // Tie goes to whoever did not win last; a lone requester
                    // always wins and still updates the round-robin pointer.
                    win       = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    owner_d   = win;
                    last_d    = win;
                    s_addr_d  = win ? m1_addr  : m0_addr;
                    s_wdata_d = win ? m1_wdata : m0_wdata;
                    s_wstrb_d = win ? m1_wstrb : m0_wstrb;
                    state_d   = BUSY;
`ifdef MMIO_ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end
            end
            BUSY: begin
                // Owner's valid is deliberately ignored here; the latched copy
                // drives the access to completion.
                if (s_ready) begin
                    if (owner_q) m1_rdata_d = s_rdata;
                    else         m0_rdata_d = s_rdata;
                    state_d = DONE;
                end
`ifdef MMIO_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    if (owner_q) m1_rdata_d = 32'hFFFF_FFFF;
                    else         m0_rdata_d = 32'hFFFF_FFFF;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode only from registered state.
    always_comb begin
        s_valid  = (state_q == BUSY);
        grant    = 2'b00;
        if (state_q == BUSY || state_q == DONE)
            grant = owner_q ? 2'b10 : 2'b01;
        m0_ready = (state_q == DONE) && !owner_q;
        m1_ready = (state_q == DONE) &&  owner_q;
        m0_rdata = m0_rdata_q;
        m1_rdata = m1_rdata_q;
        s_addr   = s_addr_q;
        s_wdata  = s_wdata_q;
        s_wstrb  = s_wstrb_q;
        timeout  = timeout_q;
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter. Inputs change and outputs are sampled on
// the falling edge, so every check sees the state after the last rising edge.
module tb_mmio_arbiter;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam int STALL = 2;
`else
    localparam int TO    = 16;
    localparam int STALL = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    mmio_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    task automatic do_reset;
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid: got %b want 0", s_valid); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
        checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", {m0_ready, m1_ready}); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {m0_rdata, m1_rdata}); end
        checks++; if ({s_addr, s_wdata, s_wstrb} !== 68'd0) begin errors++; $display("FAIL rst_s_fields: got %h want 0", {s_addr, s_wdata, s_wstrb}); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout); end
        reset = 0;
    endtask

    task automatic test_single_read;
        m0_valid = 1; m0_addr = 32'h4000_0004; m0_wstrb = 4'b0000;
        s_ready = 1; s_rdata = 32'h0000_00A5;
        @(negedge clk); // BUSY
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rd_s_valid: got %b want 1", s_valid); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rd_grant: got %b want 01", grant); end
        checks++; if (s_addr !== 32'h4000_0004) begin errors++; $display("FAIL rd_s_addr: got %h want 40000004", s_addr); end
        checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL rd_early_ready: got %b want 00", {m0_ready, m1_ready}); end
        @(negedge clk); // DONE
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rd_m0_ready: got %b want 1", m0_ready); end
        checks++; if (m0_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL rd_m0_rdata: got %h want 000000a5", m0_rdata); end
        checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'd0) begin errors++; $display("FAIL rd_m1_untouched: got %b/%h want 0/0", m1_ready, m1_rdata); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_done_s_valid: got %b want 0", s_valid); end
        m0_valid = 0; s_ready = 0;
        @(negedge clk); // IDLE
        checks++; if (m0_ready !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rd_idle: got ready %b grant %b want 0/00", m0_ready, grant); end
        checks++; if (m0_rdata !== 32'h0000_00A5 || s_addr !== 32'h4000_0004) begin errors++; $display("FAIL rd_hold: got %h/%h want a5/40000004", m0_rdata, s_addr); end
    endtask

    task automatic test_ties;
        logic [1:0]  exp_g;
        logic [31:0] exp_a;
        do_reset();
        m0_valid = 1; m0_addr = 32'h4000_0100;
        m1_valid = 1; m1_addr = 32'h4000_0200;
        s_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_g   = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_a   = (i % 2 == 0) ? 32'h4000_0100 : 32'h4000_0200;
            s_rdata = 32'hD0 + i;
            @(negedge clk); // BUSY
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL tie_grant[%0d]: got %b want %b", i, grant, exp_g); end
            checks++; if (s_addr !== exp_a) begin errors++; $display("FAIL tie_addr[%0d]: got %h want %h", i, s_addr, exp_a); end
            @(negedge clk); // DONE
            checks++; if ({m1_ready, m0_ready} !== exp_g) begin errors++; $display("FAIL tie_ready[%0d]: got %b want %b", i, {m1_ready, m0_ready}, exp_g); end
            checks++; if ((i % 2 == 0 ? m0_rdata : m1_rdata) !== 32'hD0 + i) begin errors++; $display("FAIL tie_rdata[%0d]: got %h/%h want %h", i, m0_rdata, m1_rdata, 32'hD0 + i); end
            @(negedge clk); // IDLE
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle_grant[%0d]: got %b want 00", i, grant); end
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
    endtask

    task automatic test_write_stall;
        m1_valid = 1; m1_addr = 32'h4000_0000; m1_wdata = 32'h3C; m1_wstrb = 4'b0001;
        s_ready = 0; s_rdata = 32'h1234_5678;
        for (int b = 1; b <= STALL + 1; b++) begin
            @(negedge clk); // BUSY cycle b
            checks++;
            if (s_valid !== 1'b1 || grant !== 2'b10 || s_addr !== 32'h4000_0000 ||
                s_wdata !== 32'h3C || s_wstrb !== 4'b0001 || m1_ready !== 1'b0) begin
                errors++;
                $display("FAIL wr_busy[%0d]: got v%b g%b a%h d%h s%b r%b want v1 g10 a40000000 d3c s0001 r0",
                         b, s_valid, grant, s_addr, s_wdata, s_wstrb, m1_ready);
            end
            if (b == STALL + 1) s_ready = 1;
        end
        @(negedge clk); // DONE
        checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL wr_ready: got m1 %b m0 %b want 1/0", m1_ready, m0_ready); end
        checks++; if (m1_rdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_rdata: got %h want 12345678", m1_rdata); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wr_timeout: got %b want 0", timeout); end
        m1_valid = 0; s_ready = 0;
        @(negedge clk); // IDLE
        checks++; if (m1_ready !== 1'b0 || s_wstrb !== 4'b0001) begin errors++; $display("FAIL wr_after: got ready %b wstrb %b want 0/0001", m1_ready, s_wstrb); end
    endtask

    task automatic test_timeout;
        m0_valid = 1; m0_addr = 32'h4000_0008; m0_wstrb = 0;
        s_ready = 0;
`ifdef MMIO_ARB_TIMEOUT_EN
        for (int b = 1; b <= TO; b++) begin
            @(negedge clk);
            checks++; if (s_valid !== 1'b1 || timeout !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL to_busy[%0d]: got v%b t%b r%b want 1/0/0", b, s_valid, timeout, m0_ready); end
        end
        @(negedge clk); // DONE via abort
        checks++; if (m0_ready !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got ready %b timeout %b want 1/1", m0_ready, timeout); end
        checks++; if (m0_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL to_rdata: got %h want ffffffff", m0_rdata); end
        m0_valid = 0;
        @(negedge clk);
        checks++; if (timeout !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL to_after: got t%b r%b want 0/0", timeout, m0_ready); end
`else
        for (int b = 1; b <= 100; b++) begin
            @(negedge clk);
            checks++; if (s_valid !== 1'b1 || timeout !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL nto_busy[%0d]: got v%b t%b r%b want 1/0/0", b, s_valid, timeout, m0_ready); end
        end
        s_ready = 1; s_rdata = 32'h55;
        @(negedge clk); // DONE
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h55) begin errors++; $display("FAIL nto_done: got r%b d%h want 1/55", m0_ready, m0_rdata); end
        m0_valid = 0; s_ready = 0;
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_busy;
        m0_valid = 1; m0_addr = 32'h4000_000C; s_ready = 0;
        @(negedge clk); // BUSY 1
        @(negedge clk); // BUSY 2
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rmb_busy: got %b want 1", s_valid); end
        reset = 1;
        #1;
        checks++; if (s_valid !== 1'b0 || grant !== 2'b00 || {m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL rmb_async: got v%b g%b r%b want 0/00/00", s_valid, grant, {m0_ready, m1_ready}); end
        checks++; if (s_addr !== 32'd0) begin errors++; $display("FAIL rmb_s_addr: got %h want 0", s_addr); end
        m0_valid = 0; s_ready = 1; s_rdata = 32'hBEEF;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        checks++; if (m0_ready !== 1'b0 || s_valid !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rmb_no_completion: got r%b v%b g%b want 0/0/00", m0_ready, s_valid, grant); end
        m0_valid = 1; m1_valid = 1;
        @(negedge clk); // BUSY
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmb_tie_grant: got %b want 01", grant); end
        @(negedge clk); // DONE
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hBEEF) begin errors++; $display("FAIL rmb_tie_done: got r%b d%h want 1/beef", m0_ready, m0_rdata); end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_drop_valid;
        m0_valid = 1; m0_addr = 32'h4000_0010; s_ready = 0;
        @(negedge clk); // BUSY 1
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL dv_grant: got %b want 01", grant); end
        m0_valid = 0;
        @(negedge clk); // BUSY 2
        checks++; if (s_valid !== 1'b1 || s_addr !== 32'h4000_0010) begin errors++; $display("FAIL dv_still_busy: got v%b a%h want 1/40000010", s_valid, s_addr); end
        s_ready = 1; s_rdata = 32'h77;
        @(negedge clk); // DONE
        checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h77) begin errors++; $display("FAIL dv_done: got r%b d%h want 1/77", m0_ready, m0_rdata); end
        s_ready = 0;
        @(negedge clk); // IDLE
        checks++; if (m0_ready !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL dv_once: got r%b g%b want 0/00", m0_ready, grant); end
        @(negedge clk);
        checks++; if (m0_ready !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL dv_no_regrant: got r%b v%b want 0/0", m0_ready, s_valid); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_ties();
        test_write_stall();
        test_timeout();
        test_reset_mid_busy();
        test_drop_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
